// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out serializer.
package piso_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-word input handshake and serial-bit output handshake of the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = piso_pkg::DEF_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             sout_last;
  logic             busy;

  modport master (
    output in_data,
    output in_valid,
    output sout_ready,
    input  in_ready,
    input  sout,
    input  sout_valid,
    input  sout_last,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  sout_ready,
    output in_ready,
    output sout,
    output sout_valid,
    output sout_last,
    output busy
  );

endinterface

// File: rtl/piso_hold_buf.sv
// One-entry word buffer with a full flag; load takes priority over unload.
module piso_hold_buf
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dout <= '0;
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Shifts accepted parallel words out one bit per transfer, with a one-word
// hold buffer so consecutive words stream without a bubble.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic clr,
  piso_serializer_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic             hb_full;
  logic [WIDTH-1:0] hb_data;
  logic             accept;
  logic             xfer;
  logic             last_xfer;
  logic             hb_load;
  logic             hb_unload;

  // in_ready depends only on the buffer flag, never on sout_ready.
  always_comb begin
    accept    = bus.in_valid && !hb_full;
    xfer      = (state == SHIFT) && bus.sout_ready;
    last_xfer = xfer && (cnt == LAST);
    hb_load   = accept && (state == SHIFT) && !last_xfer;
    hb_unload = last_xfer && hb_full;
  end

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk    (clk),
    .clr    (clr),
    .load   (hb_load),
    .unload (hb_unload),
    .din    (bus.in_data),
    .dout   (hb_data),
    .full   (hb_full)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= bus.in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_xfer) begin
            // Buffered word has priority; otherwise a same-cycle accept bypasses.
            cnt <= '0;
            if (hb_full) begin
              shreg <= hb_data;
            end else if (accept) begin
              shreg <= bus.in_data;
            end else begin
              shreg <= '0;
              state <= IDLE;
            end
          end else if (xfer) begin
            shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            cnt   <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout_last  = (state == SHIFT) && (cnt == LAST);
  assign bus.in_ready   = !hb_full;
  assign bus.busy       = (state == SHIFT) || hb_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// checked every cycle against a bit-queue model, plus literal beat sequences.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) if0 ();
  piso_serializer_if #(.WIDTH(4)) if1 ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
    .clk (clk),
    .clr (clr),
    .bus (if0.slave)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
    .clk (clk),
    .clr (clr),
    .bus (if1.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each DUT is a FIFO of pending {last,bit} beats holding at most two
  // words; a word is accepted whenever fewer than two words are outstanding.
  logic [1:0] mf   [2][8];
  int         mcnt [2];

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      mcnt[0] = 0;
      mcnt[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic       v;
        logic       r;
        logic [3:0] d;
        logic       b;
        int         words;
        bit         acc;
        bit         xf;
        v     = (i == 0) ? if0.in_valid   : if1.in_valid;
        r     = (i == 0) ? if0.sout_ready : if1.sout_ready;
        d     = (i == 0) ? if0.in_data    : if1.in_data;
        words = (mcnt[i] + 3) / 4;
        acc   = v && (words < 2);
        xf    = (mcnt[i] > 0) && r;
        if (xf) begin
          for (int j = 0; j < 7; j++) mf[i][j] = mf[i][j+1];
          mcnt[i]--;
        end
        if (acc) begin
          for (int k = 0; k < 4; k++) begin
            b = (i == 0) ? d[3-k] : d[k];
            mf[i][mcnt[i]] = {(k == 3), b};
            mcnt[i]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clr === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        logic sv, so, sl, ir, bz;
        sv = (i == 0) ? if0.sout_valid : if1.sout_valid;
        so = (i == 0) ? if0.sout       : if1.sout;
        sl = (i == 0) ? if0.sout_last  : if1.sout_last;
        ir = (i == 0) ? if0.in_ready   : if1.in_ready;
        bz = (i == 0) ? if0.busy       : if1.busy;
        chk($sformatf("sout_valid[%0d]", i), 32'(sv), 32'(mcnt[i] > 0));
        if (mcnt[i] > 0) begin
          chk($sformatf("sout[%0d]", i), 32'(so), 32'(mf[i][0][0]));
          chk($sformatf("sout_last[%0d]", i), 32'(sl), 32'(mf[i][0][1]));
        end
        chk($sformatf("in_ready[%0d]", i), 32'(ir), 32'(((mcnt[i] + 3) / 4) < 2));
        chk($sformatf("busy[%0d]", i), 32'(bz), 32'(mcnt[i] > 0));
      end
    end
  end

  // Beat log: a transfer is decided here, half a cycle before the edge.
  logic [1:0] log0[$];
  logic [1:0] log1[$];

  always @(negedge clk) begin
    if (if0.sout_valid && if0.sout_ready) log0.push_back({if0.sout_last, if0.sout});
    if (if1.sout_valid && if1.sout_ready) log1.push_back({if1.sout_last, if1.sout});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Offer a word and hold in_valid until it is taken; lowcnt counts stalled cycles.
  task automatic send(input int dut, input logic [3:0] w, output int lowcnt);
    logic rdy;
    int   budget;
    lowcnt = 0;
    budget = 0;
    if (dut == 0) begin if0.in_data = w; if0.in_valid = 1'b1; end
    else          begin if1.in_data = w; if1.in_valid = 1'b1; end
    forever begin
      @(negedge clk);
      rdy = (dut == 0) ? if0.in_ready : if1.in_ready;
      if (!rdy) lowcnt++;
      @(posedge clk);
      #1;
      if (rdy) break;
      budget++;
      if (budget > 20) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        break;
      end
    end
    if (dut == 0) if0.in_valid = 1'b0;
    else          if1.in_valid = 1'b0;
  endtask

  task automatic check_log(input int dut, input string nm, input logic [15:0] bits,
                           input logic [15:0] lasts, input int n);
    logic [1:0] e;
    int sz;
    sz = (dut == 0) ? log0.size() : log1.size();
    chk({nm, "_count"}, 32'(sz), 32'(n));
    for (int k = 0; k < n && k < sz; k++) begin
      e = (dut == 0) ? log0[k] : log1[k];
      chk($sformatf("%s_bit%0d", nm, k), 32'(e[0]), 32'(bits[n-1-k]));
      chk($sformatf("%s_last%0d", nm, k), 32'(e[1]), 32'(lasts[n-1-k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lc;
    if0.in_data = '0; if0.in_valid = 1'b0; if0.sout_ready = 1'b1;
    if1.in_data = '0; if1.in_valid = 1'b0; if1.sout_ready = 1'b1;

    // Reset values while clr is held low
    #12;
    chk("rst_sout", 32'(if0.sout), 0);
    chk("rst_sout_valid", 32'(if0.sout_valid), 0);
    chk("rst_sout_last", 32'(if0.sout_last), 0);
    chk("rst_busy", 32'(if0.busy), 0);
    chk("rst_in_ready", 32'(if0.in_ready), 1);
    #10 clr = 1'b1;
    idle(2);

    // Single word 1001
    log0.delete();
    send(0, 4'b1001, lc);
    idle(6);
    check_log(0, "single", 16'b1001, 16'b0001, 4);
    chk("single_idle_after", 32'(if0.sout_valid), 0);

    // Back-to-back words via the hold buffer
    log0.delete();
    send(0, 4'b1010, lc);
    send(0, 4'b1011, lc);
    chk("b2b_no_stall", 32'(lc), 0);
    idle(10);
    check_log(0, "b2b", 16'b1010_1011, 16'b0001_0001, 8);

    // Bypass: second word offered exactly on the last-bit transfer
    log0.delete();
    send(0, 4'b1100, lc);
    idle(3);
    send(0, 4'b0110, lc);
    chk("bypass_no_stall", 32'(lc), 0);
    idle(6);
    check_log(0, "bypass", 16'b1100_0110, 16'b0001_0001, 8);

    // Downstream stall after the second bit
    log0.delete();
    send(0, 4'b1110, lc);
    idle(2);
    if0.sout_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_sout", 32'(if0.sout), 1);
      chk("stall_last", 32'(if0.sout_last), 0);
      tick();
    end
    if0.sout_ready = 1'b1;
    idle(4);
    check_log(0, "stall", 16'b1110, 16'b0001, 4);

    // Continuous offer of three words; third waits for the first to finish
    log0.delete();
    send(0, 4'b1111, lc);
    send(0, 4'b0000, lc);
    send(0, 4'b1001, lc);
    chk("stream_ready_low_cycles", 32'(lc), 3);
    idle(12);
    check_log(0, "stream", 16'b1111_0000_1001, 16'b0001_0001_0001, 12);

    // Reset mid-word with a word buffered
    log0.delete();
    send(0, 4'b1011, lc);
    send(0, 4'b0101, lc);
    tick();
    check_log(0, "prereset", 16'b10, 16'b00, 2);
    clr = 1'b0;
    #1;
    chk("midrst_sout_valid", 32'(if0.sout_valid), 0);
    chk("midrst_busy", 32'(if0.busy), 0);
    chk("midrst_in_ready", 32'(if0.in_ready), 1);
    chk("midrst_sout", 32'(if0.sout), 0);
    chk("midrst_sout_last", 32'(if0.sout_last), 0);
    @(negedge clk);
    #2;
    log0.delete();
    clr = 1'b1;
    idle(6);
    chk("postrst_no_beats", 32'(log0.size()), 0);
    chk("postrst_sout_valid", 32'(if0.sout_valid), 0);

    // LSB-first instance
    log1.delete();
    send(1, 4'b1110, lc);
    idle(6);
    check_log(1, "lsb", 16'b0111, 16'b0001, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
